// File: rtl/iob_timer_alarm_if.sv
// Native CPU bus bundle (valid/address/wdata/wstrb/rdata/ready) for iob_timer_alarm.
interface iob_timer_alarm_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic                  valid;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_timer_alarm.sv
// Compare/alarm stage for the free-running timer: sticky match flag, irq, miss counter.
// Optional periodic re-arm built only when ALARM_PERIODIC_EN is defined.
module iob_timer_alarm #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int COUNT_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  iob_timer_alarm_if.slave    bus,
  input  logic [COUNT_W-1:0]  timer_value,
  output logic                irq
);

  localparam int HALF_W = COUNT_W / 2;

  typedef enum logic [2:0] {
    A_CTRL   = 3'd0,
    A_STATUS = 3'd1,
    A_CMP_LO = 3'd2,
    A_CMP_HI = 3'd3,
    A_PER_LO = 3'd4,
    A_PER_HI = 3'd5,
    A_MISS   = 3'd6,
    A_RSVD   = 3'd7
  } reg_addr_e;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] nw,
                                               input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old;
    for (int unsigned i = 0; i < DATA_W/8; i++)
      if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  reg_addr_e           addr;
  logic                wr;
  logic                we_ctrl, w1c, we_cmp_lo, we_cmp_hi, miss_clr;
  logic                en, ie, flag, periodic_on;
  logic [7:0]          miss;
  logic [COUNT_W-1:0]  cmp, cmp_reload, diff;
  logic [HALF_W-1:0]   shadow;
  logic                match;
  logic [DATA_W-1:0]   rd_mux;

  assign addr      = reg_addr_e'(bus.address[2:0]);
  assign wr        = bus.valid & (|bus.wstrb);
  assign we_ctrl   = wr & (addr == A_CTRL) & bus.wstrb[0];
  assign w1c       = wr & (addr == A_STATUS) & bus.wstrb[0] & bus.wdata[0];
  assign we_cmp_lo = wr & (addr == A_CMP_LO);
  assign we_cmp_hi = wr & (addr == A_CMP_HI);
  assign miss_clr  = wr & (addr == A_MISS);

  // Modular difference: MSB clear means the count has reached or passed cmp, even across wrap.
  assign diff  = timer_value - cmp;
  assign match = en & ~diff[COUNT_W-1];
  assign irq   = flag & ie;

`ifdef ALARM_PERIODIC_EN
  logic               periodic;
  logic [COUNT_W-1:0] per;

  assign periodic_on = periodic;
  assign cmp_reload  = cmp + per;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      periodic <= 1'b0;
      per      <= '0;
    end else begin
      if (we_ctrl) periodic <= bus.wdata[1];
      if (wr && addr == A_PER_LO)
        per[HALF_W-1:0] <= merge(per[HALF_W-1:0], bus.wdata, bus.wstrb);
      if (wr && addr == A_PER_HI)
        per[COUNT_W-1:HALF_W] <= merge(per[COUNT_W-1:HALF_W], bus.wdata, bus.wstrb);
    end
  end
`else
  assign periodic_on = 1'b0;
  assign cmp_reload  = cmp;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en     <= 1'b0;
      ie     <= 1'b0;
      flag   <= 1'b0;
      miss   <= '0;
      cmp    <= '0;
      shadow <= '0;
    end else begin
      // Match set beats W1C; a miss only counts when software is not acknowledging.
      if (match)    flag <= 1'b1;
      else if (w1c) flag <= 1'b0;

      if (miss_clr)
        miss <= '0;
      else if (match && flag && !w1c && miss != 8'hFF)
        miss <= miss + 8'd1;

      if (we_ctrl) begin
        en <= bus.wdata[0];
        ie <= bus.wdata[2];
      end else if (match && !periodic_on) begin
        en <= 1'b0;
      end

      if (we_cmp_lo) shadow <= merge(shadow, bus.wdata, bus.wstrb);

      if (we_cmp_hi)
        cmp <= {merge(cmp[COUNT_W-1:HALF_W], bus.wdata, bus.wstrb), shadow};
      else if (match && periodic_on)
        cmp <= cmp_reload;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:   rd_mux[2:0] = {ie, periodic_on, en};
      A_STATUS: rd_mux[0]   = flag;
      A_CMP_LO: rd_mux      = cmp[HALF_W-1:0];
      A_CMP_HI: rd_mux      = cmp[COUNT_W-1:HALF_W];
`ifdef ALARM_PERIODIC_EN
      A_PER_LO: rd_mux      = per[HALF_W-1:0];
      A_PER_HI: rd_mux      = per[COUNT_W-1:HALF_W];
`endif
      A_MISS:   rd_mux[7:0] = miss;
      default:  rd_mux      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= bus.valid;
      bus.rdata <= bus.valid ? rd_mux : '0;
    end
  end

endmodule
